// File: rtl/antilog_val.sv
// Approximate 8x8 -> 16 unsigned multiplier using Mitchell's logarithmic method.
// Both operands are turned into fixed-point log2 values, summed, then shifted back.
module antilog_val (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  n_var_1,
  input  logic [7:0]  n_var_2,
  output logic [15:0] c
);

  // Priority leading-one detector: the highest set bit wins.
  function automatic logic [2:0] lod(input logic [7:0] n);
    logic [2:0] k;
    k = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (n[i]) k = i[2:0];
    end
    return k;
  endfunction

  function automatic logic [6:0] frac(input logic [7:0] n, input logic [2:0] k);
    logic [7:0] sh;
    sh = n << (3'd7 - k);
    return sh[6:0];
  endfunction

  logic [2:0]  k1, k2;
  logic [6:0]  f1, f2;
  logic [10:0] log_sum;
  logic [3:0]  k_sum;
  logic [6:0]  f_sum;
  logic [22:0] mant_sh;
  logic        zero_op;
  logic [15:0] c_d, c_q;

  always_comb begin
    k1      = lod(n_var_1);
    k2      = lod(n_var_2);
    f1      = frac(n_var_1, k1);
    f2      = frac(n_var_2, k2);
    // A carry out of the fraction sum lands in the integer field here.
    log_sum = {({1'b0, k1} + {1'b0, k2}), 7'b0} + {4'b0, f1} + {4'b0, f2};
    k_sum   = log_sum[10:7];
    f_sum   = log_sum[6:0];
    mant_sh = {15'b0, 1'b1, f_sum} << k_sum;
    zero_op = (n_var_1 == '0) || (n_var_2 == '0);
    c_d     = zero_op ? '0 : mant_sh[22:7];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) c_q <= '0;
    else     c_q <= c_d;
  end

  assign c = c_q;

endmodule

// File: tb/tb_antilog_val.sv
// Self-checking bench for antilog_val: directed vectors, streaming, random and full sweep.
module tb_antilog_val;

  logic        clk;
  logic        rst;
  logic [7:0]  n_var_1;
  logic [7:0]  n_var_2;
  logic [15:0] c;

  int tests;
  int fails;

  antilog_val dut (
    .clk     (clk),
    .rst     (rst),
    .n_var_1 (n_var_1),
    .n_var_2 (n_var_2),
    .c       (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: Mitchell approximation with plain integer arithmetic.
  function automatic int unsigned model(input int unsigned a, input int unsigned b);
    int unsigned ka, kb, fa, fb, l, kk, ff;
    if (a == 0 || b == 0) return 0;
    ka = 0; while ((a >> (ka + 1)) != 0) ka++;
    kb = 0; while ((b >> (kb + 1)) != 0) kb++;
    fa = ((a - (1 << ka)) * 128) / (1 << ka);
    fb = ((b - (1 << kb)) * 128) / (1 << kb);
    l  = (ka + kb) * 128 + fa + fb;
    kk = l / 128;
    ff = l % 128;
    return ((128 + ff) * (1 << kk)) / 128;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input int unsigned exp);
    tests++;
    if (got !== exp[15:0]) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_bound(input string name, input logic [15:0] got, input int unsigned a,
                             input int unsigned b);
    tests++;
    if (int'(got) > int'(a * b)) begin
      fails++;
      $display("FAIL %s: got %0d exceeds true product %0d", name, got, a * b);
    end
  endtask

  // Drive on falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    n_var_1 = a;
    n_var_2 = b;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0] a, b;
    tests = 0;
    fails = 0;

    vecs[0] = '{8'd128, 8'd128, 16'd16384, "pow2_128x128"};
    vecs[1] = '{8'd1,   8'd200, 16'd200,   "one_x_200"};
    vecs[2] = '{8'd0,   8'd255, 16'd0,     "zero_a"};
    vecs[3] = '{8'd77,  8'd0,   16'd0,     "zero_b"};
    vecs[4] = '{8'd3,   8'd3,   16'd8,     "carry_3x3"};
    vecs[5] = '{8'd255, 8'd255, 16'd65024, "carry_max"};
    vecs[6] = '{8'd6,   8'd6,   16'd32,    "carry_6x6"};
    vecs[7] = '{8'd3,   8'd5,   16'd14,    "nocarry_3x5"};
    vecs[8] = '{8'd10,  8'd12,  16'd112,   "nocarry_10x12"};
    vecs[9] = '{8'd2,   8'd7,   16'd14,    "nocarry_2x7"};

    // Reset phase: output stays zero across edges with a nonzero operand pair present.
    rst = 1'b1;
    n_var_1 = 8'd2;
    n_var_2 = 8'd2;
    #2;
    check("reset_async", c, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", c, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_after_reset", c, 4);

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b);
      check(vecs[i].name, c, vecs[i].exp);
    end

    // Streaming: bump A then B alternately, one new pair per cycle.
    a = 8'd2;
    b = 8'd2;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) a = a + 8'd1;
      else            b = b + 8'd1;
      apply(a, b);
      check("stream", c, model(a, b));
      check_bound("stream_bound", c, a, b);
    end

    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      apply(a, b);
      check("random", c, model(a, b));
      check_bound("random_bound", c, a, b);
    end

    // Exhaustive sweep with an asynchronous reset pulse between edges part way through.
    for (int i = 0; i < 65536; i++) begin
      a = 8'(i >> 8);
      b = 8'(i & 255);
      apply(a, b);
      check("sweep", c, model(a, b));
      if (i == 30000) begin
        #1;
        rst = 1'b1;
        #1;
        check("sweep_async_reset", c, 0);
        rst = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
